cpu_bus_x: RTL and testbench

Parametrised successor of the RISC5 CPU-to-bus adapter. It sits between cpu_core_x and the system word bus and converts each CPU access (word or byte, read or write) into registered word-bus cycles. Adds a configurable address width, selectable byte-write mode (read-modify-write or native byte lanes), and a bus-timeout watchdog with a sticky error and captured fault address.

---
 rtl/cpu_bus_pkg.sv | 20 ++
 rtl/cpu_bus_lane.sv | 33 +++
 rtl/cpu_bus_x.sv | 189 ++++++++++++++++++
 tb/tb_cpu_bus_x.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-to-word-bus adapter.
package cpu_bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0]  BUS_SEL_ALL   = 4'hF;
    localparam logic [DATA_W-1:0] READ_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bus_lane.sv
// Byte-lane helper: read extraction, write replication/select, and RMW merge.
module cpu_bus_lane
    import cpu_bus_pkg::*;
#(
    parameter int unsigned BYTE_MODE = 0
) (
    input  logic [LANE_W-1:0] lane,
    input  logic              ben,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rd_word_c,
    output logic [DATA_W-1:0] wr_word_c,
    output logic [SEL_W-1:0]  wr_sel_c,
    output logic [DATA_W-1:0] mrg_word_c
);

    logic [7:0] rd_byte;

    // Little-endian lane selection for reads and merges; byte lane n is bits 8n+7:8n.
    always_comb begin
        rd_byte    = rdata[{lane, 3'b000} +: 8];
        rd_word_c  = ben ? {24'b0, rd_byte} : rdata;
        mrg_word_c = rdata;
        mrg_word_c[{lane, 3'b000} +: 8] = wdata[7:0];
        wr_sel_c   = BUS_SEL_ALL;
        wr_word_c  = wdata;
        if (ben && (BYTE_MODE != 0)) begin
            wr_sel_c  = SEL_W'(4'b0001 << lane);
            wr_word_c = {4{wdata[7:0]}};
        end
    end

endmodule

// File: rtl/cpu_bus_x.sv
// CPU-to-word-bus adapter with optional native byte lanes and a bus-timeout watchdog.
module cpu_bus_x
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned BYTE_MODE = 0,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TO_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_stb,
    input  logic              cpu_we,
    input  logic              cpu_ben,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_dout,
    output logic [31:0]       cpu_din,
    output logic              cpu_ack,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [31:0]       bus_dout,
    input  logic [31:0]       bus_din,
    input  logic              bus_ack,
    input  logic              err_clr,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_EN ? TIMEOUT - 1 : 0);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                ben_q;
    logic [DATA_W-1:0]   data_q;
    logic [TO_W-1:0]     to_cnt;

    logic [LANE_W-1:0]   lane_addr;
    logic                lane_ben;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   rd_word_c;
    logic [DATA_W-1:0]   wr_word_c;
    logic [SEL_W-1:0]    wr_sel_c;
    logic [DATA_W-1:0]   mrg_word_c;
    logic                ack_v;
    logic                to_fire;

    // Lane helper sees the live CPU request in IDLE, the latched request otherwise.
    always_comb begin
        lane_addr  = addr_q[1:0];
        lane_ben   = ben_q;
        lane_wdata = data_q;
        if (state == IDLE) begin
            lane_addr  = cpu_addr[1:0];
            lane_ben   = cpu_ben;
            lane_wdata = cpu_dout;
        end
    end

    // Ack only counts during an active strobe; ack beats a same-cycle timeout.
    always_comb begin
        ack_v   = bus_stb & bus_ack;
        to_fire = TO_EN & bus_stb & ~bus_ack & (to_cnt == TO_LAST);
    end

    cpu_bus_lane #(
        .BYTE_MODE (BYTE_MODE)
    ) u_lane (
        .lane       (lane_addr),
        .ben        (lane_ben),
        .wdata      (lane_wdata),
        .rdata      (bus_din),
        .rd_word_c  (rd_word_c),
        .wr_word_c  (wr_word_c),
        .wr_sel_c   (wr_sel_c),
        .mrg_word_c (mrg_word_c)
    );

    // Transaction FSM with registered CPU/bus outputs, watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            ben_q       <= 1'b0;
            data_q      <= '0;
            to_cnt      <= '0;
            cpu_din     <= '0;
            cpu_ack     <= 1'b0;
            bus_stb     <= 1'b0;
            bus_we      <= 1'b0;
            bus_sel     <= 4'h0;
            bus_addr    <= '0;
            bus_dout    <= '0;
            timeout_err <= 1'b0;
            err_addr    <= '0;
        end else begin
            cpu_ack <= 1'b0;

            if (TO_EN && bus_stb && !bus_ack) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (to_fire) begin
                timeout_err <= 1'b1;
                if (!timeout_err) begin
                    err_addr <= addr_q;
                end
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cpu_stb) begin
                        addr_q   <= cpu_addr;
                        ben_q    <= cpu_ben;
                        data_q   <= cpu_dout;
                        bus_addr <= cpu_addr[ADDR_W-1:2];
                        bus_stb  <= 1'b1;
                        to_cnt   <= '0;
                        if (!cpu_we) begin
                            state   <= RD;
                            bus_we  <= 1'b0;
                            bus_sel <= BUS_SEL_ALL;
                        end else if (cpu_ben && (BYTE_MODE == 0)) begin
                            state   <= RMW_RD;
                            bus_we  <= 1'b0;
                            bus_sel <= BUS_SEL_ALL;
                        end else begin
                            state    <= WR;
                            bus_we   <= 1'b1;
                            bus_sel  <= wr_sel_c;
                            bus_dout <= wr_word_c;
                        end
                    end
                end
                RD: begin
                    if (ack_v || to_fire) begin
                        cpu_din <= ack_v ? rd_word_c : READ_ERR_DATA;
                        bus_stb <= 1'b0;
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end
                end
                WR: begin
                    if (ack_v || to_fire) begin
                        bus_stb <= 1'b0;
                        bus_we  <= 1'b0;
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end
                end
                RMW_RD: begin
                    if (ack_v) begin
                        bus_stb  <= 1'b0;
                        bus_dout <= mrg_word_c;
                        state    <= RMW_WR;
                    end else if (to_fire) begin
                        bus_stb <= 1'b0;
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end
                end
                RMW_WR: begin
                    // First cycle here is the mandatory idle gap between phases.
                    if (!bus_stb) begin
                        bus_stb <= 1'b1;
                        bus_we  <= 1'b1;
                        to_cnt  <= '0;
                    end else if (ack_v || to_fire) begin
                        bus_stb <= 1'b0;
                        bus_we  <= 1'b0;
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_x.sv
// Directed bench: dut0 uses read-modify-write bytes and a 4-cycle watchdog, dut1 native byte lanes.
module tb_cpu_bus_x;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_stb0 = 1'b0, cpu_stb1 = 1'b0;
    logic        cpu_we = 1'b0, cpu_ben = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [31:0] cpu_dout = '0;
    logic [31:0] mem = '0;
    logic        err_clr = 1'b0;
    int          ack_wait = -1;

    logic [31:0] cpu_din0, cpu_din1, bus_dout0, bus_dout1;
    logic        cpu_ack0, cpu_ack1, bus_stb0, bus_stb1, bus_we0, bus_we1;
    logic [3:0]  bus_sel0, bus_sel1;
    logic [21:0] bus_addr0, bus_addr1;
    logic        bus_ack0, bus_ack1, terr0, terr1;
    logic [23:0] err_addr0, err_addr1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_bus_x #(.ADDR_W(24), .BYTE_MODE(0), .TIMEOUT(4), .TO_W(8)) dut0 (
        .clk(clk), .rst(rst), .cpu_stb(cpu_stb0), .cpu_we(cpu_we), .cpu_ben(cpu_ben),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din0), .cpu_ack(cpu_ack0),
        .bus_stb(bus_stb0), .bus_we(bus_we0), .bus_sel(bus_sel0), .bus_addr(bus_addr0),
        .bus_dout(bus_dout0), .bus_din(mem), .bus_ack(bus_ack0), .err_clr(err_clr),
        .timeout_err(terr0), .err_addr(err_addr0)
    );

    cpu_bus_x #(.ADDR_W(24), .BYTE_MODE(1), .TIMEOUT(255), .TO_W(8)) dut1 (
        .clk(clk), .rst(rst), .cpu_stb(cpu_stb1), .cpu_we(cpu_we), .cpu_ben(cpu_ben),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din1), .cpu_ack(cpu_ack1),
        .bus_stb(bus_stb1), .bus_we(bus_we1), .bus_sel(bus_sel1), .bus_addr(bus_addr1),
        .bus_dout(bus_dout1), .bus_din(mem), .bus_ack(bus_ack1), .err_clr(err_clr),
        .timeout_err(terr1), .err_addr(err_addr1)
    );

    // Bus slave: acks after ack_wait wait states (negative means never).
    int run0 = 0, run1 = 0;
    always @(posedge clk) begin
        run0 <= (bus_stb0 && !bus_ack0) ? run0 + 1 : 0;
        run1 <= (bus_stb1 && !bus_ack1) ? run1 + 1 : 0;
    end
    assign bus_ack0 = bus_stb0 && (run0 == ack_wait);
    assign bus_ack1 = bus_stb1 && (run1 == ack_wait);

    // Per-DUT activity monitors.
    int          stb_cyc [2] = '{0, 0};
    int          phases  [2] = '{0, 0};
    int          acks    [2] = '{0, 0};
    logic        prev    [2] = '{1'b0, 1'b0};
    logic [31:0] wdata   [2];
    logic [3:0]  wsel    [2];
    logic [3:0]  rsel    [2];
    logic [21:0] last_a  [2];

    always @(negedge clk) begin
        prev[0] <= bus_stb0;
        if (bus_stb0) begin
            stb_cyc[0] <= stb_cyc[0] + 1;
            last_a[0]  <= bus_addr0;
            if (!bus_we0) rsel[0] <= bus_sel0;
        end
        if (bus_stb0 && !prev[0]) phases[0] <= phases[0] + 1;
        if (bus_stb0 && bus_we0 && bus_ack0) begin
            wdata[0] <= bus_dout0;
            wsel[0]  <= bus_sel0;
        end
        if (cpu_ack0) acks[0] <= acks[0] + 1;
    end

    always @(negedge clk) begin
        prev[1] <= bus_stb1;
        if (bus_stb1) begin
            stb_cyc[1] <= stb_cyc[1] + 1;
            last_a[1]  <= bus_addr1;
            if (!bus_we1) rsel[1] <= bus_sel1;
        end
        if (bus_stb1 && !prev[1]) phases[1] <= phases[1] + 1;
        if (bus_stb1 && bus_we1 && bus_ack1) begin
            wdata[1] <= bus_dout1;
            wsel[1]  <= bus_sel1;
        end
        if (cpu_ack1) acks[1] <= acks[1] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    int lat, n_stb, n_ph, n_ack;

    // One CPU access on DUT d; lat is the cycle of cpu_ack counted from the cpu_stb cycle.
    task automatic txn(input int d, input logic we, input logic ben, input logic [23:0] addr,
                       input logic [31:0] data, input int waits, input logic [31:0] rmem);
        int b_stb, b_ph, b_ack;
        ack_wait = waits;
        mem      = rmem;
        @(negedge clk);
        cpu_we = we; cpu_ben = ben; cpu_addr = addr; cpu_dout = data;
        b_stb = stb_cyc[d]; b_ph = phases[d]; b_ack = acks[d];
        if (d == 0) cpu_stb0 = 1'b1; else cpu_stb1 = 1'b1;
        @(negedge clk);
        cpu_stb0 = 1'b0; cpu_stb1 = 1'b0;
        lat = 1;
        while (!(d == 0 ? cpu_ack0 : cpu_ack1) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        #1;
        n_stb = stb_cyc[d] - b_stb;
        n_ph  = phases[d] - b_ph;
        n_ack = acks[d] - b_ack;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cpu_ack", 32'(cpu_ack0), 32'd0);
        chk("rst_bus_stb", 32'(bus_stb0), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel0), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr0), 32'd0);
        chk("rst_cpu_din", cpu_din0, 32'd0);
        chk("rst_terr", 32'(terr0), 32'd0);
        chk("rst_err_addr", 32'(err_addr0), 32'd0);
        rst = 1'b1;

        // Word read, two wait states.
        txn(0, 1'b0, 1'b0, 24'h000104, 32'h0, 2, 32'hDEADBEEF);
        chk("wrd_lat", 32'(lat), 32'd4);
        chk("wrd_data", cpu_din0, 32'hDEADBEEF);
        chk("wrd_addr", 32'(last_a[0]), 32'h000041);
        chk("wrd_sel", 32'(rsel[0]), 32'hF);
        chk("wrd_stb_cyc", 32'(n_stb), 32'd3);
        chk("wrd_one_ack", 32'(n_ack), 32'd1);

        // Byte read lane 2, zero wait.
        txn(0, 1'b0, 1'b1, 24'h000102, 32'h0, 0, 32'h44332211);
        chk("brd_lat", 32'(lat), 32'd2);
        chk("brd_data", cpu_din0, 32'h00000033);
        chk("brd_sel", 32'(rsel[0]), 32'hF);

        // Read-modify-write byte.
        txn(0, 1'b1, 1'b1, 24'h000101, 32'h000000AA, 0, 32'h44332211);
        chk("rmw_lat", 32'(lat), 32'd4);
        chk("rmw_phases", 32'(n_ph), 32'd2);
        chk("rmw_stb_cyc", 32'(n_stb), 32'd2);
        chk("rmw_wdata", wdata[0], 32'h4433AA11);
        chk("rmw_wsel", 32'(wsel[0]), 32'hF);
        chk("rmw_one_ack", 32'(n_ack), 32'd1);

        // Ack on the last cycle before the watchdog would fire.
        txn(0, 1'b0, 1'b0, 24'h000104, 32'h0, 3, 32'h12345678);
        chk("edge_lat", 32'(lat), 32'd5);
        chk("edge_data", cpu_din0, 32'h12345678);
        chk("edge_terr", 32'(terr0), 32'd0);

        // Read timeout.
        txn(0, 1'b0, 1'b0, 24'h000200, 32'h0, -1, 32'h0);
        chk("to_lat", 32'(lat), 32'd5);
        chk("to_stb_cyc", 32'(n_stb), 32'd4);
        chk("to_data", cpu_din0, 32'hFFFFFFFF);
        chk("to_terr", 32'(terr0), 32'd1);
        chk("to_err_addr", 32'(err_addr0), 32'h000200);

        // Second timeout keeps the first fault address.
        txn(0, 1'b1, 1'b0, 24'h000300, 32'h1, -1, 32'h0);
        chk("to2_lat", 32'(lat), 32'd5);
        chk("to2_err_addr", 32'(err_addr0), 32'h000200);
        chk("to2_terr", 32'(terr0), 32'd1);

        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("clr_terr", 32'(terr0), 32'd0);

        // Native byte lanes.
        txn(1, 1'b1, 1'b1, 24'h000103, 32'h0000005C, 1, 32'h0);
        chk("nb_lat", 32'(lat), 32'd3);
        chk("nb_phases", 32'(n_ph), 32'd1);
        chk("nb_wsel", 32'(wsel[1]), 32'h8);
        chk("nb_wdata", wdata[1], 32'h5C5C5C5C);
        txn(1, 1'b1, 1'b1, 24'h000100, 32'h0000003C, 0, 32'h0);
        chk("nb0_lat", 32'(lat), 32'd2);
        chk("nb0_wsel", 32'(wsel[1]), 32'h1);
        chk("nb0_wdata", wdata[1], 32'h3C3C3C3C);

        // Reset while the RMW read phase is waiting.
        ack_wait = -1;
        n_ack = acks[0];
        @(negedge clk);
        cpu_we = 1'b1; cpu_ben = 1'b1; cpu_addr = 24'h000101; cpu_dout = 32'h77;
        cpu_stb0 = 1'b1;
        @(negedge clk); cpu_stb0 = 1'b0;
        chk("mid_stb_on", 32'(bus_stb0), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("mid_stb_off", 32'(bus_stb0), 32'd0);
        chk("mid_sel", 32'(bus_sel0), 32'd0);
        chk("mid_addr", 32'(bus_addr0), 32'd0);
        chk("mid_cpu_ack", 32'(cpu_ack0), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_no_ack", 32'(acks[0] - n_ack), 32'd0);

        txn(0, 1'b1, 1'b0, 24'h000104, 32'hCAFEF00D, 1, 32'h0);
        chk("post_lat", 32'(lat), 32'd3);
        chk("post_wdata", wdata[0], 32'hCAFEF00D);
        chk("post_wsel", 32'(wsel[0]), 32'hF);
        chk("post_phases", 32'(n_ph), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench time limit");
    end

endmodule
